sort_engine: RTL and testbench
==============================

# sort_engine

Parametrised in-place sorting engine holding `DEPTH` words of `WIDTH` bits in an internal register file. It is the successor to the fixed 8×8 sort top: the host loads the array, pulses start, and reads back the sorted array. New in this generation:
- ascending or descending order, and signed or unsigned compare, both selected per run;
- early exit after the first pass with no swaps;
- a busy flag and a pass counter for host visibility.

## Interface
Parameters:
- `WIDTH`, 8, data word width in bits (≥1)
- `DEPTH`, 8, number of words (≥2)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `s`  in  1  start pulse; sampled in IDLE or DONE only
- `desc`  in  1  1 = descending order; latched when start is accepted
- `signed_cmp`  in  1  1 = two's-complement compare; latched when start is accepted
- `wr_en`  in  1  load-port write strobe
- `addr`  in  $clog2(DEPTH)  load/read address
- `DataIn`  in  WIDTH  write data
- `Rd`  in  1  read strobe
- `DataOut`  out  WIDTH  registered read data
- `busy`  out  1  high while a sort is running
- `done`  out  1  high from sort completion until the next start or write
- `passes`  out  $clog2(DEPTH)+1  passes executed in the last or current run

## Operation
- States: IDLE, CMP, PASS_END, DONE.
- IDLE/DONE, with `wr_en`=1: `mem[addr]` ← `DataIn`. `done` clears.
- IDLE/DONE, with `s`=1 and `wr_en`=0: latch `desc` and `signed_cmp`; set `j`=0, `lim`=DEPTH-1, `swapped`=0, `passes`=0; go to CMP. If `s` and `wr_en` are both high, the write wins and start is ignored.
- CMP, one compare per cycle on `a`=`mem[j]` and `b`=`mem[j+1]`:
  - Out of order means `a`>`b` when ascending, `a`<`b` when descending, using the latched signedness.
  - If out of order, swap the two words and set `swapped`.
  - Equal words are never swapped, so the sort is stable.
  - If `j`==`lim`-1, go to PASS_END; otherwise increment `j`.
- PASS_END, one cycle:
  - Increment `passes`.
  - If `swapped`=0 or `lim`==1, go to DONE.
  - Otherwise decrement `lim`, set `j`=0, clear `swapped`, and go to CMP.
- DONE: `done`=1. Leave on start (to CMP) or on write (to IDLE).
- `Rd` is honoured in every state: `DataOut` ← `mem[addr]` on the next edge, and holds its value when `Rd`=0. Reading during a sort returns the in-progress contents.
- `wr_en` and `s` are ignored while `busy`=1.
- `addr` ≥ DEPTH (non-power-of-two DEPTH): writes are dropped and reads return 0.

## Timing
- Reset values:
  - state IDLE
  - `busy`=0, `done`=0, `passes`=0, `DataOut`=0
  - all memory words 0
  - `j`=0, `lim`=DEPTH-1
- Reset asserted mid-sort aborts immediately to these values; the array contents are lost.
- Start accepted at edge 0:
  - `busy`=1 from cycle 1.
  - Each pass costs `lim` CMP cycles plus 1 PASS_END cycle.
  - `done` rises and `busy` falls on the edge leaving the last PASS_END.
- Cycle counts for DEPTH=8:
  - Already-sorted input: 8 busy cycles, `done`=1 from cycle 9.
  - Fully reversed input: 28 CMP + 7 PASS_END = 35 busy cycles, `done`=1 from cycle 36.
- Write latency: 1 cycle. A write on edge t is visible to a `Rd` sampled on edge t+1.
- Read latency: 1 cycle.
- `passes` updates on the PASS_END edge.

## Structure
- Package `sort_pkg`:
  - `sort_state_e` enum (IDLE, CMP, PASS_END, DONE)
  - a function `out_of_order(a, b, desc, signed_cmp)` parametrised through the module's WIDTH
- Sub-module `sort_cmp_swap`: combinational compare/swap on `WIDTH` bits. It outputs `lo_word`, `hi_word`, and `swap`.
- The top holds the FSM, counters, register file, and read port.

## Test plan
- Load [5,3,8,1,9,2,7,4], `desc`=0, `signed_cmp`=0, start → readback [1,2,3,4,5,7,8,9] and `done`=1.
- Load [1..8] ascending, start → `passes`=1 and `done` at cycle 9. Load [8..1], start → `passes`=7, `done` at cycle 36, readback [1..8].
- Load [7F,80,00,FF,01,FE,10,F0], `signed_cmp`=1, ascending → [80,F0,FE,FF,00,01,10,7F]. Rerun with `signed_cmp`=0 → [00,01,10,7F,80,F0,FE,FF].
- Load [3,3,1,2,2,0,5,5], `desc`=1 → [5,5,3,3,2,2,1,0].
- Raise `wr_en` and `s` while busy → memory and run unchanged, final result still correct. Raise `wr_en` and `s` together in IDLE → the write lands and no sort starts.
- Drop `rst_n` low at cycle 10 of a reversed sort → `busy`=0, `done`=0, `passes`=0, `DataOut`=0, and reads of every address return 0.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types and the ordering rule used by the sort engine.
package sort_pkg;

  // Widest word the ordering helper accepts; callers zero-extend into it.
  localparam int MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CMP      = 2'd1,
    PASS_END = 2'd2,
    DONE     = 2'd3
  } sort_state_e;

  // True when a (lower index) and b (higher index) must be exchanged.
  // 'width' is the caller's word width. A signed compare flips the sign
  // bit of both operands so that a plain unsigned compare orders them as
  // two's-complement values. Equal operands never report out of order.
  function automatic logic out_of_order(
    input logic [MAX_WIDTH-1:0] a,
    input logic [MAX_WIDTH-1:0] b,
    input logic                 desc,
    input logic                 signed_cmp,
    input int unsigned          width
  );
    logic [MAX_WIDTH-1:0] bias;
    logic [MAX_WIDTH-1:0] ak;
    logic [MAX_WIDTH-1:0] bk;
    if (signed_cmp) begin
      bias = {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (width - 32'd1);
    end else begin
      bias = {MAX_WIDTH{1'b0}};
    end
    ak = a ^ bias;
    bk = b ^ bias;
    if (desc) begin
      return (ak < bk);
    end else begin
      return (ak > bk);
    end
  endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// Combinational compare/exchange of one adjacent word pair.
module sort_cmp_swap
  import sort_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             desc,
  input  logic             signed_cmp,
  output logic [WIDTH-1:0] lo_word,
  output logic [WIDTH-1:0] hi_word,
  output logic             swap
);

  // Decide the exchange and route the pair into its ordered slots.
  always_comb begin
    swap    = out_of_order(MAX_WIDTH'(a), MAX_WIDTH'(b), desc, signed_cmp, WIDTH);
    lo_word = a;
    hi_word = b;
    if (swap) begin
      lo_word = b;
      hi_word = a;
    end else begin
      lo_word = a;
      hi_word = b;
    end
  end

endmodule

// File: rtl/sort_engine.sv
// In-place bubble sort engine with early exit, host load and read ports.
module sort_engine
  import sort_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s,
  input  logic                     desc,
  input  logic                     signed_cmp,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         DataIn,
  input  logic                     Rd,
  output logic [WIDTH-1:0]         DataOut,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   passes
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] ONE_A    = AW'(1);
  localparam logic [AW-1:0] LIM_INIT = AW'(DEPTH - 1);
  localparam logic [AW:0]   ONE_P    = (AW+1)'(1);

  sort_state_e      state;
  sort_state_e      next_state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    j;
  logic [AW-1:0]    j_next;
  logic [AW-1:0]    lim;
  logic             swapped;
  logic             desc_lat;
  logic             sgn_lat;
  logic             start_acc;
  logic             wr_acc;
  logic             addr_ok;
  logic             last_cmp;
  logic             pass_final;
  logic [WIDTH-1:0] lo_word;
  logic [WIDTH-1:0] hi_word;
  logic             swap;

  // Out-of-range addresses only exist when DEPTH is not a power of two.
  assign addr_ok    = (32'(addr) < DEPTH);
  assign j_next     = j + ONE_A;
  assign last_cmp   = (j == (lim - ONE_A));
  // A pass with no exchanges proves the array sorted; a one-compare pass is the last possible.
  assign pass_final = (!swapped) || (lim == ONE_A);

  sort_cmp_swap #(.WIDTH(WIDTH)) u_cmp_swap (
    .a          (mem[j]),
    .b          (mem[j_next]),
    .desc       (desc_lat),
    .signed_cmp (sgn_lat),
    .lo_word    (lo_word),
    .hi_word    (hi_word),
    .swap       (swap)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a write beats a simultaneous start.
  always_comb begin
    next_state = state;
    start_acc  = 1'b0;
    wr_acc     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (wr_en) begin
          wr_acc     = 1'b1;
          next_state = IDLE;
        end else if (s) begin
          start_acc  = 1'b1;
          next_state = CMP;
        end else begin
          next_state = state;
        end
      end
      CMP: begin
        if (last_cmp) begin
          next_state = PASS_END;
        end else begin
          next_state = CMP;
        end
      end
      PASS_END: begin
        if (pass_final) begin
          next_state = DONE;
        end else begin
          next_state = CMP;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Sort control counters, latched run options and host status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j        <= {AW{1'b0}};
      lim      <= LIM_INIT;
      swapped  <= 1'b0;
      passes   <= {(AW+1){1'b0}};
      desc_lat <= 1'b0;
      sgn_lat  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy <= (next_state == CMP) || (next_state == PASS_END);
      done <= (next_state == DONE);
      case (state)
        IDLE, DONE: begin
          if (start_acc) begin
            desc_lat <= desc;
            sgn_lat  <= signed_cmp;
            j        <= {AW{1'b0}};
            lim      <= LIM_INIT;
            swapped  <= 1'b0;
            passes   <= {(AW+1){1'b0}};
          end
        end
        CMP: begin
          if (swap) begin
            swapped <= 1'b1;
          end
          if (!last_cmp) begin
            j <= j_next;
          end
        end
        PASS_END: begin
          passes <= passes + ONE_P;
          if (!pass_final) begin
            lim     <= lim - ONE_A;
            j       <= {AW{1'b0}};
            swapped <= 1'b0;
          end
        end
        default: begin
          j <= {AW{1'b0}};
        end
      endcase
    end
  end

  // Register file: host writes when idle, pair exchange while comparing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {WIDTH{1'b0}};
      end
    end else if (wr_acc && addr_ok) begin
      mem[addr] <= DataIn;
    end else if ((state == CMP) && swap) begin
      mem[j]      <= lo_word;
      mem[j_next] <= hi_word;
    end
  end

  // Registered read port, live in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DataOut <= {WIDTH{1'b0}};
    end else if (Rd) begin
      DataOut <= addr_ok ? mem[addr] : {WIDTH{1'b0}};
    end else begin
      DataOut <= DataOut;
    end
  end

endmodule

// File: tb/tb_sort_engine.sv
// Self-checking bench for sort_engine (WIDTH=8, DEPTH=8).
module tb_sort_engine;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AW = 3;

  typedef logic [W-1:0] arr_t [D];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s = 1'b0;
  logic          desc = 1'b0;
  logic          signed_cmp = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [W-1:0]  DataIn = '0;
  logic          Rd = 1'b0;
  logic [W-1:0]  DataOut;
  logic          busy;
  logic          done;
  logic [AW:0]   passes;

  int compared   = 0;
  int mismatched = 0;

  sort_engine #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .s(s), .desc(desc), .signed_cmp(signed_cmp),
    .wr_en(wr_en), .addr(addr), .DataIn(DataIn), .Rd(Rd),
    .DataOut(DataOut), .busy(busy), .done(done), .passes(passes)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int key(input logic [W-1:0] x, input logic sg);
    return sg ? int'($signed(x)) : int'(x);
  endfunction

  // x sits before y and the chosen order wants them exchanged
  function automatic bit ooo(input logic [W-1:0] x, input logic [W-1:0] y, input logic d, input logic sg);
    return d ? (key(x, sg) < key(y, sg)) : (key(x, sg) > key(y, sg));
  endfunction

  // stable insertion sort
  function automatic arr_t model_sort(input arr_t a, input logic d, input logic sg);
    arr_t r;
    logic [W-1:0] v;
    int k;
    r = a;
    for (int i = 1; i < D; i++) begin
      v = r[i];
      k = i;
      while (k > 0 && ooo(r[k-1], v, d, sg)) begin
        r[k] = r[k-1];
        k--;
      end
      r[k] = v;
    end
    return r;
  endfunction

  // Each element moves left at most one slot per pass; one clean pass confirms,
  // unless the shrinking window has already reached a single compare.
  function automatic int model_passes(input arr_t a, input logic d, input logic sg);
    int m;
    int c;
    m = 0;
    for (int i = 0; i < D; i++) begin
      c = 0;
      for (int k = 0; k < i; k++) begin
        if (ooo(a[k], a[i], d, sg)) c++;
      end
      if (c > m) m = c;
    end
    return (m + 1 < D - 1) ? m + 1 : D - 1;
  endfunction

  function automatic int model_busy(input int p);
    int t;
    t = 0;
    for (int k = 1; k <= p; k++) t += (D - k) + 1;
    return t;
  endfunction

  // ---------------- bus tasks ----------------
  task automatic load(input arr_t v);
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      wr_en  = 1'b1;
      addr   = AW'(i);
      DataIn = v[i];
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic read_word(input int a, output logic [W-1:0] d);
    @(negedge clk);
    addr = AW'(a);
    Rd   = 1'b1;
    @(negedge clk);
    Rd = 1'b0;
    d  = DataOut;
  endtask

  task automatic readback(input string tag, input arr_t exp);
    logic [W-1:0] d;
    for (int i = 0; i < D; i++) begin
      read_word(i, d);
      check($sformatf("%s[%0d]", tag, i), 32'(d), 32'(exp[i]));
    end
  endtask

  // Start a run and follow it to done. inject_at>0 drives wr_en and s for two
  // cycles from that busy cycle onward.
  task automatic run(input string tag, input logic d, input logic sg, input int inject_at,
                     input int exp_passes, input int exp_busy);
    int cyc;
    int busy_cnt;
    @(negedge clk);
    desc       = d;
    signed_cmp = sg;
    s          = 1'b1;
    @(negedge clk);
    s   = 1'b0;
    cyc = 1;
    check({tag, "_busy_c1"}, 32'(busy), 32'd1);
    busy_cnt = 0;
    while (!done && cyc < 400) begin
      if (busy) busy_cnt++;
      if (inject_at > 0 && cyc == inject_at) begin
        wr_en  = 1'b1;
        s      = 1'b1;
        addr   = '0;
        DataIn = 8'hAA;
      end else if (inject_at > 0 && cyc == inject_at + 2) begin
        wr_en = 1'b0;
        s     = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    wr_en = 1'b0;
    s     = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check({tag, "_passes"}, 32'(passes), 32'(exp_passes));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_busy + 1));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    arr_t v;
    arr_t e;
    arr_t z;
    logic [W-1:0] rd;
    logic dr;
    logic sr;
    int p;

    for (int i = 0; i < D; i++) z[i] = '0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_passes", 32'(passes), 32'd0);
    check("rst_dataout", 32'(DataOut), 32'd0);
    rst_n = 1'b1;
    readback("rst_mem", z);

    // basic ascending unsigned
    v = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd9, 8'd2, 8'd7, 8'd4};
    e = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd7, 8'd8, 8'd9};
    load(v);
    p = model_passes(v, 1'b0, 1'b0);
    run("basic", 1'b0, 1'b0, 0, p, model_busy(p));
    readback("basic", e);

    // already sorted: one pass, done at cycle 9
    v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    load(v);
    check("load_clears_done", 32'(done), 32'd0);
    run("sorted", 1'b0, 1'b0, 0, 1, 8);
    readback("sorted", v);

    // fully reversed: seven passes, done at cycle 36
    e = v;
    v = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    load(v);
    run("reversed", 1'b0, 1'b0, 0, 7, 35);
    readback("reversed", e);

    // signed then unsigned on the same words
    v = '{8'h7F, 8'h80, 8'h00, 8'hFF, 8'h01, 8'hFE, 8'h10, 8'hF0};
    load(v);
    p = model_passes(v, 1'b0, 1'b1);
    run("signed", 1'b0, 1'b1, 0, p, model_busy(p));
    e = '{8'h80, 8'hF0, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h10, 8'h7F};
    readback("signed", e);
    p = model_passes(e, 1'b0, 1'b0);
    run("unsigned", 1'b0, 1'b0, 0, p, model_busy(p));
    e = '{8'h00, 8'h01, 8'h10, 8'h7F, 8'h80, 8'hF0, 8'hFE, 8'hFF};
    readback("unsigned", e);

    // descending with duplicates
    v = '{8'd3, 8'd3, 8'd1, 8'd2, 8'd2, 8'd0, 8'd5, 8'd5};
    load(v);
    p = model_passes(v, 1'b1, 1'b0);
    run("desc", 1'b1, 1'b0, 0, p, model_busy(p));
    e = '{8'd5, 8'd5, 8'd3, 8'd3, 8'd2, 8'd2, 8'd1, 8'd0};
    readback("desc", e);

    // wr_en and s raised while busy are ignored
    v = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd9, 8'd2, 8'd7, 8'd4};
    load(v);
    p = model_passes(v, 1'b0, 1'b0);
    run("inject", 1'b0, 1'b0, 3, p, model_busy(p));
    readback("inject", model_sort(v, 1'b0, 1'b0));

    // wr_en and s together in IDLE: write lands, no sort starts
    @(negedge clk);
    wr_en  = 1'b1;
    addr   = 3'd0;
    DataIn = 8'hFF;
    @(negedge clk);
    addr   = 3'd3;
    DataIn = 8'h5A;
    s      = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    s     = 1'b0;
    check("wr_s_busy", 32'(busy), 32'd0);
    check("wr_s_done", 32'(done), 32'd0);
    @(negedge clk);
    check("wr_s_busy2", 32'(busy), 32'd0);
    read_word(3, rd);
    check("wr_s_data", 32'(rd), 32'h5A);
    read_word(0, rd);
    check("wr_s_unsorted", 32'(rd), 32'hFF);

    // randomized runs against the reference model
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < D; i++) begin
        if (t % 2 == 0) v[i] = W'($urandom_range(0, 255));
        else            v[i] = W'({$urandom_range(0, 1), 5'd0, $urandom_range(0, 3)});
      end
      dr = 1'($urandom_range(0, 1));
      sr = 1'($urandom_range(0, 1));
      load(v);
      p = model_passes(v, dr, sr);
      run($sformatf("rand%0d", t), dr, sr, 0, p, model_busy(p));
      readback($sformatf("rand%0d", t), model_sort(v, dr, sr));
    end

    // reset in the middle of a reversed sort
    v = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    load(v);
    read_word(0, rd);
    @(negedge clk);
    s = 1'b1;
    @(negedge clk);
    s = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_passes", 32'(passes), 32'd0);
    check("abort_dataout", 32'(DataOut), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    readback("abort_mem", z);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
